// File: rtl/lbist_scheduler_pkg.sv
// Shared types for the LBIST scheduler: FSM state encoding and watchdog width.
package lbist_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } sched_state_e;

    localparam int WDOG_W = 32;

endpackage

// File: rtl/lbist_scheduler_if.sv
// Requester-side and controller-side handshakes of the LBIST scheduler.
interface lbist_scheduler_if #(
    parameter int NUM_REQS  = 4,
    parameter int NUM_SEEDS = 8
);
    logic [NUM_REQS-1:0]  req_val;
    logic [NUM_REQS-1:0]  req_rdy;
    logic [NUM_REQS-1:0]  resp_val;
    logic [NUM_SEEDS-1:0] resp_msg;
    logic [NUM_REQS-1:0]  resp_rdy;
    logic                 ctrl_req_val;
    logic                 ctrl_req_rdy;
    logic                 ctrl_resp_val;
    logic [NUM_SEEDS-1:0] ctrl_resp_msg;
    logic                 ctrl_resp_rdy;

    // scheduler side
    modport slave (
        input  req_val, resp_rdy, ctrl_req_rdy, ctrl_resp_val, ctrl_resp_msg,
        output req_rdy, resp_val, resp_msg, ctrl_req_val, ctrl_resp_rdy
    );

    // requesters + controller side
    modport master (
        output req_val, resp_rdy, ctrl_req_rdy, ctrl_resp_val, ctrl_resp_msg,
        input  req_rdy, resp_val, resp_msg, ctrl_req_val, ctrl_resp_rdy
    );
endinterface

// File: rtl/lbist_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping; one-hot grant plus index.
module lbist_rr_arbiter #(
    parameter int NUM_REQS = 4
) (
    input  logic [NUM_REQS-1:0]         req,
    input  logic [$clog2(NUM_REQS)-1:0] ptr,
    output logic [NUM_REQS-1:0]         grant,
    output logic [$clog2(NUM_REQS)-1:0] idx,
    output logic                        any
);
    localparam int IDX_W = $clog2(NUM_REQS);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any       = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end
endmodule

// File: rtl/lbist_scheduler.sv
// Shares one lbist_controller among NUM_REQS requesters with round-robin grants.
// Define LBIST_SCHED_TIMEOUT_EN to add the WAIT watchdog with sticky timeout and drain.
module lbist_scheduler
    import lbist_sched_pkg::*;
#(
    parameter int NUM_REQS       = 4,
    parameter int NUM_SEEDS      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    lbist_scheduler_if.slave            bus,
    output logic [$clog2(NUM_REQS)-1:0] grant_id,
    output logic                        busy,
    output logic                        timeout
);
    localparam int IDX_W = $clog2(NUM_REQS);

    sched_state_e         state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_SEEDS-1:0] result;
    logic [NUM_REQS-1:0]  arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 drain;
    logic                 wdog_hit;
    logic                 grant_hs;

    lbist_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
        .req   (bus.req_val),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign busy     = (state != IDLE);
    assign grant_hs = (state == IDLE) && !drain && arb_any;

    always_comb begin
        state_nxt         = state;
        bus.req_rdy       = '0;
        bus.resp_val      = '0;
        bus.resp_msg      = '0;
        bus.ctrl_req_val  = 1'b0;
        // a timed-out run's late response is swallowed outside WAIT
        bus.ctrl_resp_rdy = drain && (state != WAIT);
        case (state)
            IDLE: begin
                if (!drain) bus.req_rdy = arb_grant;
                if (grant_hs) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.ctrl_req_val = 1'b1;
                if (bus.ctrl_req_rdy) state_nxt = WAIT;
            end
            WAIT: begin
                bus.ctrl_resp_rdy = 1'b1;
                if (bus.ctrl_resp_val || wdog_hit) state_nxt = RETURN;
            end
            RETURN: begin
                bus.resp_val[grant_id] = 1'b1;
                bus.resp_msg           = result;
                if (bus.resp_rdy[grant_id]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            result   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_hs) grant_id <= arb_idx;
            if (state == WAIT) begin
                if (bus.ctrl_resp_val) result <= bus.ctrl_resp_msg;
                else if (wdog_hit)     result <= '0;
            end
            if ((state == RETURN) && bus.resp_rdy[grant_id])
                rr_ptr <= (grant_id == IDX_W'(NUM_REQS - 1)) ? '0 : grant_id + 1'b1;
        end
    end

`ifdef LBIST_SCHED_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog;

    // a response arriving on the limit cycle wins over the timeout
    assign wdog_hit = (state == WAIT) && !bus.ctrl_resp_val &&
                      (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog    <= '0;
            timeout <= 1'b0;
            drain   <= 1'b0;
        end else begin
            if ((state == ISSUE) && bus.ctrl_req_rdy) wdog <= '0;
            else if (state == WAIT)                   wdog <= wdog + 1'b1;
            if (wdog_hit) begin
                timeout <= 1'b1;
                drain   <= 1'b1;
            end else if (drain && (state != WAIT) && bus.ctrl_resp_val) begin
                drain <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign wdog_hit   = 1'b0;
    assign drain      = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_lbist_scheduler.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_lbist_scheduler;
    localparam int NR = 4;
    localparam int NS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    lbist_scheduler_if #(.NUM_REQS(NR), .NUM_SEEDS(NS)) bus ();

    lbist_scheduler #(.NUM_REQS(NR), .NUM_SEEDS(NS), .TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [7:0] msg;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg_q[$];
    int         grant_log[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ctrl_hs = 0;
    int         req_stall = 0;
    int         ctrl_lat = 2;
    bit         no_resp = 1'b0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_exp(int p, logic [7:0] m);
        exp_t e;
        e.port = p;
        e.msg  = m;
        exp_q.push_back(e);
        msg_q.push_back(m);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (|bus.req_rdy) check("req_rdy_onehot", 32'($onehot(bus.req_rdy)), 32'd1);
            if (|(bus.req_val & bus.req_rdy)) grant_log.push_back(onehot_idx(bus.req_rdy));
            if (bus.ctrl_req_val && bus.ctrl_req_rdy) ctrl_hs++;
            if (|bus.resp_val) begin
                check("resp_val_onehot", 32'($onehot(bus.resp_val)), 32'd1);
                if (|(bus.resp_val & bus.resp_rdy)) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL resp_unexpected: got port %0d msg %0h expected none",
                                 onehot_idx(bus.resp_val), bus.resp_msg);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("resp_port", 32'(onehot_idx(bus.resp_val)), 32'(e.port));
                        check("resp_msg", 32'(bus.resp_msg), 32'(e.msg));
                    end
                end
            end else begin
                check("resp_msg_idle", 32'(bus.resp_msg), 32'd0);
            end
        end
    end

    // lbist_controller model
    initial begin
        int   seen;
        int   lat;
        bit   pend;
        logic rq_v, rq_hs, rs_hs;
        seen = 0; lat = 0; pend = 1'b0;
        bus.ctrl_req_rdy  = 1'b0;
        bus.ctrl_resp_val = 1'b0;
        bus.ctrl_resp_msg = '0;
        forever begin
            @(negedge clk);
            rq_v  = bus.ctrl_req_val;
            rq_hs = bus.ctrl_req_val & bus.ctrl_req_rdy;
            rs_hs = bus.ctrl_resp_val & bus.ctrl_resp_rdy;
            @(posedge clk);
            #1;
            if (reset) begin
                seen = 0; lat = 0; pend = 1'b0;
                bus.ctrl_req_rdy  = 1'b0;
                bus.ctrl_resp_val = 1'b0;
            end else if (!pend) begin
                if (rq_hs) begin
                    bus.ctrl_req_rdy = 1'b0;
                    pend = 1'b1; seen = 0; lat = ctrl_lat;
                end else if (rq_v) begin
                    if (seen < req_stall) begin
                        seen++;
                        bus.ctrl_req_rdy = 1'b0;
                    end else begin
                        bus.ctrl_req_rdy = 1'b1;
                    end
                end
            end else begin
                if (rs_hs) begin
                    bus.ctrl_resp_val = 1'b0;
                    pend = 1'b0;
                end else if (!bus.ctrl_resp_val) begin
                    if (lat > 0) lat--;
                    else if (!no_resp) begin
                        bus.ctrl_resp_val = 1'b1;
                        bus.ctrl_resp_msg = (msg_q.size() != 0) ? msg_q.pop_front() : 8'hEE;
                    end
                end
            end
        end
    end

    task automatic wait_idle(string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 500);
        check(nm, 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic wait_grants(int k, string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_log.size() < k && n < 500);
        check(nm, 32'(grant_log.size() >= k), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(string nm, ref logic s);
        int n = 0;
        while (!s && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(s), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   order[5];
        int   h0;
        int   n;
        logic wait_seen;
        order = '{0, 1, 2, 3, 0};

        reset        = 1'b1;
        bus.req_val  = '0;
        bus.resp_rdy = '1;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_ctrl_req_val", 32'(bus.ctrl_req_val), 32'd0);
        check("rst_ctrl_resp_rdy", 32'(bus.ctrl_resp_rdy), 32'd0);
        check("rst_resp_val", 32'(bus.resp_val), 32'd0);
        check("rst_resp_msg", 32'(bus.resp_msg), 32'd0);
        check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // contention: all four request, rr_ptr starts at 0
        grant_log.delete();
        for (int i = 0; i < 5; i++) push_exp(order[i], 8'(8'h11 * (i + 1)));
        bus.req_val = 4'b1111;
        wait_grants(5, "cont_grants");
        bus.req_val = '0;
        wait_idle("cont_done");
        for (int i = 0; i < 5; i++)
            check($sformatf("cont_order%0d", i),
                  32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(order[i]));

        // single run on port 1
        grant_log.delete();
        h0 = ctrl_hs;
        @(posedge clk);
        #1;
        push_exp(1, 8'hA5);
        bus.req_val = 4'b0010;
        @(negedge clk);
        check("single_req_rdy", 32'(bus.req_rdy), 32'h2);
        wait_grants(1, "single_grant");
        bus.req_val = '0;
        wait_idle("single_done");
        check("single_ctrl_reqs", 32'(ctrl_hs - h0), 32'd1);
        check("single_grant_id", 32'(grant_id), 32'd1);

        // backpressure on both controller request and requester response
        grant_log.delete();
        req_stall    = 5;
        bus.resp_rdy = 4'b1011;
        push_exp(2, 8'h5A);
        bus.req_val = 4'b0100;
        wait_grants(1, "bp_grant");
        bus.req_val = '0;
        wait_sig("bp_ctrl_req_seen", bus.ctrl_req_val);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_ctrl_req_held", 32'({bus.ctrl_req_val, bus.ctrl_req_rdy, busy}), 32'b101);
        end
        n = 0;
        while (bus.resp_val == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_resp_val_held", 32'(bus.resp_val), 32'h4);
            check("bp_resp_msg_held", 32'(bus.resp_msg), 32'h5A);
        end
        @(posedge clk);
        #1 bus.resp_rdy = '1;
        wait_idle("bp_done");
        req_stall = 0;

`ifdef LBIST_SCHED_TIMEOUT_EN
        // watchdog: controller never answers port 3's run
        grant_log.delete();
        no_resp = 1'b1;
        exp_q.push_back('{port: 3, msg: 8'h00});
        msg_q.push_back(8'hFF);
        bus.req_val = 4'b1000;
        wait_grants(1, "to_grant");
        bus.req_val = '0;
        wait_sig("to_wait_entry", bus.ctrl_resp_rdy);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.resp_val == 0 && n < 100);
        check("to_wait_cycles", 32'(n), 32'd16);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_resp_msg", 32'(bus.resp_msg), 32'h00);
        @(posedge clk);
        #1;
        grant_log.delete();
        bus.req_val = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_no_grant", 32'({bus.req_rdy, busy, bus.ctrl_resp_rdy}), 32'b0000_0_1);
        end
        push_exp(0, 8'h3C);
        no_resp = 1'b0;
        wait_grants(1, "drain_then_grant");
        bus.req_val = '0;
        wait_idle("drain_done");
        check("to_sticky", 32'(timeout), 32'd1);
`else
        check("timeout_tied_low", 32'(timeout), 32'd0);
`endif

        // async reset while waiting on the controller
        grant_log.delete();
        no_resp = 1'b1;
        bus.req_val = 4'b0100;
        wait_grants(1, "rst_run_grant");
        bus.req_val = '0;
        wait_seen = bus.ctrl_resp_rdy;
        n = 0;
        while (!wait_seen && n < 500) begin
            @(negedge clk);
            wait_seen = bus.ctrl_resp_rdy;
            n++;
        end
        check("rst_run_in_wait", 32'({wait_seen, busy, grant_id}), 32'b1_1_10);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_outputs",
              32'({busy, bus.ctrl_req_val, bus.ctrl_resp_rdy, bus.resp_val, bus.req_rdy}), 32'd0);
        check("mid_rst_resp_msg", 32'(bus.resp_msg), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        no_resp = 1'b0;
        msg_q.delete();

        grant_log.delete();
        push_exp(0, 8'h77);
        bus.req_val = 4'b1001;
        wait_grants(1, "post_rst_grant");
        bus.req_val = '0;
        check("post_rst_first_port", 32'((grant_log.size() > 0) ? grant_log[0] : -1), 32'd0);
        wait_idle("post_rst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
